// File: rtl/logic_unit_arbiter_if.sv
// Handshake bundle between two logic-unit requesters, the shared arbiter and the result consumer.
interface logic_unit_arbiter_if #(parameter int WIDTH = 32);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             out_valid;
    logic             out_ready;
    logic             out_id;
    logic [WIDTH-1:0] out_data;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output out_ready,
        input  req0_ready, req1_ready, out_valid, out_id, out_data
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  out_ready,
        output req0_ready, req1_ready, out_valid, out_id, out_data
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of a registered AND/OR/XOR/NOR unit between two requesters.
// Optional LOGIC_ARB_STATS_EN adds saturating per-requester accept counters.
//
// state | meaning
// EMPTY | result register holds nothing (out_valid=0)
// FULL  | result register holds an unconsumed result (out_valid=1)
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    logic_unit_arbiter_if.slave   bus
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic             slot_free;
    logic             grant_any;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] out_data_q;
    logic             out_id_q;

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   logic_op = a & b;
            2'b01:   logic_op = a | b;
            2'b10:   logic_op = a ^ b;
            default: logic_op = ~(a | b);
        endcase
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= EMPTY;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        slot_free      = (state == EMPTY) | bus.out_ready;
        grant_any      = bus.req0_valid | bus.req1_valid;
        // Contention goes to whoever did not win the last accept.
        grant_id       = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
        accept         = grant_any & slot_free & resetn;
        result         = grant_id ? logic_op(bus.req1_op, bus.req1_a, bus.req1_b)
                                  : logic_op(bus.req0_op, bus.req0_a, bus.req0_b);
        if (accept) begin
            bus.req0_ready = ~grant_id;
            bus.req1_ready = grant_id;
        end
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (bus.out_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_data_q <= '0;
            out_id_q   <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            out_data_q <= result;
            out_id_q   <= grant_id;
            last_grant <= grant_id;
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

`ifdef LOGIC_ARB_STATS_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (!grant_id && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (grant_id && grant_cnt1 != 16'hFFFF)  grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter.
module tb_logic_unit_arbiter;

    logic clock;
    logic resetn;
    int   tests = 0;
    int   fails = 0;

    logic_unit_arbiter_if #(.WIDTH(32)) bus ();

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn         = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b00;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = 2'b00;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.out_ready  = 1'b1;

        // reset state, no ready during reset
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_id",    {31'b0, bus.out_id},    32'd0);
        chk("rst_out_data",  bus.out_data,           32'd0);
        chk("rst_ready0",    {31'b0, bus.req0_ready}, 32'd0);
        @(negedge clock);
        resetn         = 1'b1;
        bus.req0_valid = 1'b0;

        // req0 OR
        @(negedge clock);
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b01;
        bus.req0_a     = 32'hF0F0_0000;
        bus.req0_b     = 32'h0000_0F0F;
        #1;
        chk("or_ready0", {31'b0, bus.req0_ready}, 32'd1);
        chk("or_ready1", {31'b0, bus.req1_ready}, 32'd0);
        @(posedge clock); #1;
        chk("or_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("or_id",    {31'b0, bus.out_id},    32'd0);
        chk("or_data",  bus.out_data,           32'hF0F0_0F0F);
        @(negedge clock);
        bus.req0_valid = 1'b0;
        @(posedge clock); #1;
        chk("consume_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("consume_hold",  bus.out_data,           32'hF0F0_0F0F);

        // req1 XOR, then stall and reset mid-stall
        @(negedge clock);
        bus.out_ready  = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 2'b10;
        bus.req1_a     = 32'hAAAA_AAAA;
        bus.req1_b     = 32'hFFFF_FFFF;
        #1;
        chk("xor_ready1", {31'b0, bus.req1_ready}, 32'd1);
        @(posedge clock); #1;
        chk("xor_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("xor_id",    {31'b0, bus.out_id},    32'd1);
        chk("xor_data",  bus.out_data,           32'h5555_5555);
        @(negedge clock); #1;
        chk("stall_ready1", {31'b0, bus.req1_ready}, 32'd0);
        @(posedge clock); #1;
        chk("stall_data", bus.out_data, 32'h5555_5555);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("midrst_valid",  {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_data",   bus.out_data,           32'd0);
        chk("midrst_ready1", {31'b0, bus.req1_ready}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // both valid: alternating grants starting with req0
        bus.out_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b00;
        bus.req0_a     = 32'hFFFF_0000;
        bus.req0_b     = 32'h0F0F_0F0F;
        bus.req1_op    = 2'b11;
        bus.req1_a     = 32'h0;
        bus.req1_b     = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", {31'b0, bus.req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'b0, bus.req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clock); #1;
            chk("rr_id",   {31'b0, bus.out_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_data", bus.out_data, (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0F0F_0000);
            @(negedge clock);
        end

        // backpressure with both valid
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0", {31'b0, bus.req0_ready}, 32'd0);
            chk("bp_ready1", {31'b0, bus.req1_ready}, 32'd0);
            @(posedge clock); #1;
            chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp_data",  bus.out_data,           32'hFFFF_FFFF);
            @(negedge clock);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_ready0", {31'b0, bus.req0_ready}, 32'd1);
        @(posedge clock); #1;
        chk("release_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("release_id",    {31'b0, bus.out_id},    32'd0);
        chk("release_data",  bus.out_data,           32'h0F0F_0000);
        @(negedge clock);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clock); #1;
        chk("drain_valid", {31'b0, bus.out_valid}, 32'd0);

`ifdef LOGIC_ARB_STATS_EN
        chk("cnt1_pre", {16'b0, grant_cnt1}, 32'd2);
        @(negedge clock);
        bus.req0_valid = 1'b1;
        repeat (70000) @(posedge clock);
        #1;
        chk("cnt0_sat", {16'b0, grant_cnt0}, 32'h0000_FFFF);
        chk("cnt1_hold", {16'b0, grant_cnt1}, 32'd2);
        @(negedge clock);
        bus.req0_valid = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
